// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle for nibble_serial_adder: operand valid/ready in, result valid/ready out.
// The slave modport is the adder; the master modport is the producer/consumer side.
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NIBBLES-1:0]   a;
  logic [4*NIBBLES-1:0]   b;
  logic                   c_in;
  logic                   op_sub;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NIBBLES-1:0]   sum;
  logic                   cout;

  modport master (
    output in_valid, a, b, c_in, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, c_in, op_sub, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial wide adder, one nibble per clock through a single 4-bit ripple adder; ADD_SUB_EN adds a - b.
// Latency: out_valid rises NIBBLES cycles after the operand accept edge.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  nibble_serial_adder_if.slave     bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    sum_sh;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            sub_q;

  logic [3:0]      b_nib;
  logic [3:0]      s_nib;
  logic            c_nib;
  logic [W-1:0]    sum_next;
  logic            init_carry;
  logic            init_sub;

`ifdef ADD_SUB_EN
  assign init_sub   = bus.op_sub;
  assign init_carry = bus.op_sub | bus.c_in;
`else
  assign init_sub   = 1'b0;
  assign init_carry = bus.c_in;
`endif

  // Subtraction is a + ~b + 1; the +1 comes from the forced initial carry.
  assign b_nib = sub_q ? ~b_sh[3:0] : b_sh[3:0];

  bit_adder u_bit_adder (
    .a    (a_sh[3:0]),
    .b    (b_nib),
    .c_in (carry),
    .s    (s_nib),
    .cout (c_nib)
  );

  always_comb begin
    sum_next          = sum_sh >> 4;
    sum_next[W-1-:4]  = s_nib;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      sub_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= init_carry;
            sub_q <= init_sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_next;
          carry  <= c_nib;
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(NIBBLES - 1)) begin
            sum_q  <= sum_next;
            cout_q <= c_nib;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed-vector bench for nibble_serial_adder (NIBBLES=4); subtract vectors only under ADD_SUB_EN.
module tb_nibble_serial_adder;
  localparam int NIB = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  nibble_serial_adder_if #(.NIBBLES(NIB)) bus ();

  nibble_serial_adder #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Accept one operation, scramble the inputs, then wait for out_valid.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        input logic [15:0] exp_sum, input logic exp_cout);
    int cycles;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = cin;
    bus.op_sub   = sub;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'(~a);
    bus.b        = 16'(~b);
    bus.c_in     = ~cin;
    bus.op_sub   = ~sub;
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'(NIB));
    check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
  endtask

  task automatic take_result(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_ovld_after_hs"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_irdy_after_hs"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    take_result("basic");

    run_op("ripple1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    take_result("ripple1");
    run_op("ripple2", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);

    // Held result while new operands are offered.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = 16'(16'h1111 * (i + 1));
      bus.b        = 16'h0101;
      @(posedge clk);
      #1;
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_sum", 32'(bus.sum), 32'hFFFF);
      check("bp_cout", 32'(bus.cout), 32'd1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    take_result("bp");
    repeat (3) @(posedge clk);
    #1;
    check("bp_no_capture", 32'(bus.out_valid), 32'd0);
    check("bp_idle", 32'(bus.in_ready), 32'd1);

    run_op("b2b1", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0);
    take_result("b2b1");
    run_op("b2b2", 16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0);
    take_result("b2b2");

    // Reset two cycles into RUN.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 16'hABCD;
    bus.b        = 16'h1111;
    bus.c_in     = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_run_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_sum", 32'(bus.sum), 32'd0);
    check("mrst_cout", 32'(bus.cout), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0);
    take_result("post_rst");

`ifdef ADD_SUB_EN
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    take_result("sub_neg");
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    take_result("sub_pos");
`else
    run_op("sub_ignored", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0);
    take_result("sub_ignored");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that drives our 4-bit ripple adder (`bit_adder`) one nibble per clock. It accepts a pair of `4*NIBBLES`-bit operands over a valid/ready handshake. Each cycle it feeds the low nibbles and the registered carry into a single `bit_adder` instance, then feeds `cout` back as the next `c_in`. It returns the assembled sum and final carry over a second valid/ready handshake. It sits between operand producers and result consumers wherever a full-width adder would be too large.

## Interface
- `NIBBLES`, default 4: operand width is `4*NIBBLES` bits; legal values are 1 or more.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operands presented.
- `in_ready` output 1: block can accept operands; high only in IDLE.
- `a` input `4*NIBBLES`: operand A.
- `b` input `4*NIBBLES`: operand B.
- `c_in` input 1: carry into nibble 0.
- `op_sub` input 1: subtract request; used only with `ADD_SUB_EN`.
- `out_valid` output 1: result available; high only in DONE.
- `out_ready` input 1: consumer takes the result.
- `sum` output `4*NIBBLES`: registered result.
- `cout` output 1: carry out of the top nibble.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid & in_ready`: capture `a`, `b` into shift registers and `c_in` into the carry register; clear the nibble counter; go to RUN.
- **RUN:**
  - Each cycle, apply `a_sh[3:0]`, `b_sh[3:0]` and the carry register to `bit_adder`.
  - Shift the adder result in at the top: `sum_sh <= {S, sum_sh[4*NIBBLES-1:4]}`.
  - Carry register <= `cout`.
  - Shift `a_sh` and `b_sh` right by 4.
  - Counter increments.
  - After the NIBBLES-th RUN cycle, load `sum`/`cout` and go to DONE.
- **DONE:**
  - `out_valid`=1; `sum` and `cout` are held stable.
  - On `out_valid & out_ready`, go to IDLE.
- **Arithmetic:** the result is `{cout,sum} = a + b + c_in`, modulo `2^(4*NIBBLES+1)`. Nibble 0 is processed first.
- **Counter width:** `$clog2(NIBBLES+1)`.
- **Operand lifetime:** `a`, `b`, `c_in` and `op_sub` need not remain stable after the accept edge.
- **Input during RUN/DONE:** `in_valid` is ignored, since `in_ready`=0.
- **Held result:** `out_ready` held low keeps the block in DONE indefinitely with outputs unchanged.
- **NIBBLES=1:** exactly one RUN cycle.
- **Reset, any state:** discards the in-flight operation immediately.
  - `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0.
  - All internal registers are 0 and the state is IDLE.

## Timing
- Accept occurs on edge T (IDLE, `in_valid`=1).
- RUN occupies edges T+1 … T+NIBBLES.
- `out_valid` rises after edge T+NIBBLES, which is NIBBLES cycles after acceptance.
- A result handshake at edge R returns the block to IDLE; `in_ready`=1 after edge R.
- Peak throughput is one operation per NIBBLES+2 cycles.
- All outputs are registered or decoded directly from state; there are no combinational paths from inputs to outputs.

## Configuration
- **`ADD_SUB_EN` defined:**
  - `op_sub` is captured at accept.
  - When `op_sub`=1, every B nibble is inverted before the adder and the initial carry is forced to 1 (`c_in` ignored). The result is `a - b`.
  - `cout`=1 means no borrow.
- **`ADD_SUB_EN` undefined:** `op_sub` is ignored and the block only adds.

## Test plan
- **Basic add:** NIBBLES=4, `a`=16'h1234, `b`=16'h4321, `c_in`=0 -> `sum`=16'h5555, `cout`=0. `out_valid` rises exactly 4 cycles after accept.
- **Full carry ripple:** `a`=16'hFFFF, `b`=16'h0001, `c_in`=0 -> `sum`=16'h0000, `cout`=1. Separately, `a`=`b`=16'hFFFF, `c_in`=1 -> `sum`=16'hFFFF, `cout`=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid` with new operands -> `sum`/`cout`/`out_valid` unchanged, `in_ready`=0, and the new operands are not captured.
- **Back-to-back:** two operations, 16'h0001+16'h0001 then 16'h00F0+16'h0010 -> results 16'h0002 then 16'h0100. The second accept occurs no earlier than 1 cycle after the first result handshake.
- **Mid-operation reset:** assert `rst_n`=0 two cycles into RUN -> `out_valid`=0, `sum`=0, `cout`=0, `in_ready`=1 immediately. After release, 16'h000F+16'h0001 gives 16'h0010.
- **Subtract (`ADD_SUB_EN` builds only):**
  - `a`=16'h0005, `b`=16'h0007, `op_sub`=1 -> `sum`=16'hFFFE, `cout`=0.
  - `a`=16'h0007, `b`=16'h0005 -> `sum`=16'h0002, `cout`=1.
